// File: rtl/pwm_capture.sv
// PWM period / high-time capture: synchronizes an asynchronous PWM input and
// measures rise-to-rise and rise-to-fall intervals in clk cycles, flagging a stuck input.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // Last count value that may still be incremented: one below all-ones.
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_lvl;
  logic                   rise;
  logic                   fall;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hf_q, hf_d;
  logic [CNT_W-1:0] period_d, high_time_d;
  logic             valid_d, stuck_d, stuck_level_d;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~prev_q;
  assign fall     = ~sync_lvl & prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= sync_lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hf_q        <= '0;
      period      <= '0;
      high_time   <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hf_q        <= hf_d;
      period      <= period_d;
      high_time   <= high_time_d;
      valid       <= valid_d;
      stuck       <= stuck_d;
      stuck_level <= stuck_level_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hf_d          = hf_q;
    period_d      = period;
    high_time_d   = high_time;
    valid_d       = 1'b0;
    stuck_d       = stuck;
    stuck_level_d = stuck_level;

    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // First edge only arms the measurement; nothing to report yet.
          if (rise) begin
            state_d = HIGH;
            cnt_d   = CNT_ONE;
            stuck_d = 1'b0;
          end
        end

        HIGH: begin
          if (fall) begin
            hf_d    = cnt_q;
            state_d = LOW;
            cnt_d   = cnt_q + CNT_ONE;
          end else if (cnt_q >= CNT_LAST) begin
            state_d       = IDLE;
            cnt_d         = '0;
            stuck_d       = 1'b1;
            stuck_level_d = sync_lvl;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        LOW: begin
          // A fall at CNT_LAST can bring cnt to all-ones here; the >= keeps it from wrapping.
          if (rise) begin
            period_d    = cnt_q;
            high_time_d = hf_q;
            valid_d     = 1'b1;
            cnt_d       = CNT_ONE;
            state_d     = HIGH;
          end else if (cnt_q >= CNT_LAST) begin
            state_d       = IDLE;
            cnt_d         = '0;
            stuck_d       = 1'b1;
            stuck_level_d = sync_lvl;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected period/high_time
// pairs, a negedge monitor pops and compares on every valid strobe.
module tb_pwm_capture;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic             pwm_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stuck;
  logic             stuck_level;

  typedef struct packed {
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] h;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   armed    = 0;
  int   prev_p   = 0;
  int   prev_h   = 0;
  logic valid_prev = 1'b0;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .pwm_in      (pwm_in),
    .period      (period),
    .high_time   (high_time),
    .valid       (valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A rise closes the previous period if one was being measured.
  task automatic rise_pwm();
    if (armed) sb.push_back('{p: CNT_W'(prev_p), h: CNT_W'(prev_h)});
    pwm_in = 1'b1;
  endtask

  task automatic run_pwm(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      rise_pwm();
      wait_cycles(h);
      pwm_in = 1'b0;
      wait_cycles(p - h);
      armed  = 1;
      prev_p = p;
      prev_h = h;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"},      period,      0);
    check({tag, "_high_time"},   high_time,   0);
    check({tag, "_valid"},       valid,       0);
    check({tag, "_stuck"},       stuck,       0);
    check({tag, "_stuck_level"}, stuck_level, 0);
  endtask

  always @(negedge clk) begin
    if (valid) begin
      exp_t e;
      check("valid_not_back_to_back", valid_prev, 0);
      check("sb_has_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_period",    period,    e.p);
        check("sb_high_time", high_time, e.h);
      end
    end
    valid_prev <= valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    pwm_in = 1'b0;
    wait_cycles(3);
    check_zero("reset");
    rst = 1'b0;
    wait_cycles(4);

    // P=10 H=3 from idle: first rise silent, then 10/3 on every later rise.
    run_pwm(10, 3, 6);
    // Minimum input: toggling every clk.
    run_pwm(2, 1, 8);
    run_pwm(10, 3, 2);

    // ena dropped mid low phase for 5 cycles: outputs hold, no valid.
    rise_pwm();
    wait_cycles(3);
    pwm_in = 1'b0;
    wait_cycles(1);
    ena   = 1'b0;
    armed = 0;
    for (int i = 0; i < 5; i++) begin
      wait_cycles(1);
      check("ena_low_valid",     valid,     0);
      check("ena_low_period",    period,    10);
      check("ena_low_high_time", high_time, 3);
      check("ena_low_stuck",     stuck,     0);
    end
    ena = 1'b1;
    wait_cycles(1);
    run_pwm(10, 3, 3);

    // Held high after a rise: stuck exactly 254 cycles after cnt=1 (rise detected 3 edges after drive).
    rise_pwm();
    armed = 0;
    wait_cycles(256);
    check("stuck_hi_early", stuck, 0);
    wait_cycles(1);
    check("stuck_hi",           stuck,       1);
    check("stuck_hi_level",     stuck_level, 1);
    check("stuck_hi_period",    period,      10);
    check("stuck_hi_high_time", high_time,   3);

    // Held low after a rise and fall: same timeout, level 0.
    pwm_in = 1'b0;
    wait_cycles(5);
    run_pwm(10, 3, 2);
    rise_pwm();
    armed = 0;
    wait_cycles(3);
    pwm_in = 1'b0;
    wait_cycles(253);
    check("stuck_lo_early", stuck, 0);
    wait_cycles(1);
    check("stuck_lo",           stuck,       1);
    check("stuck_lo_level",     stuck_level, 0);
    check("stuck_lo_period",    period,      10);
    check("stuck_lo_high_time", high_time,   3);

    // Resume with P=20 H=5: stuck clears when the first rise is detected.
    rise_pwm();
    wait_cycles(2);
    check("stuck_before_rise", stuck, 1);
    wait_cycles(1);
    check("stuck_cleared", stuck, 0);
    check("stuck_level_held", stuck_level, 0);
    wait_cycles(2);
    pwm_in = 1'b0;
    wait_cycles(15);
    armed  = 1;
    prev_p = 20;
    prev_h = 5;
    run_pwm(20, 5, 3);
    run_pwm(16, 8, 2);

    // Reset on the last high cycle while the block is still counting the high phase.
    rise_pwm();
    wait_cycles(7);
    rst = 1'b1;
    wait_cycles(1);
    rst    = 1'b0;
    pwm_in = 1'b0;
    check_zero("mid_reset");
    armed = 0;
    wait_cycles(8);
    run_pwm(16, 8, 3);

    wait_cycles(10);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16, width of the period and high-time counters and outputs; legal range 4..24.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops on pwm_in; legal range 2..3.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ena  input  1  capture enable; 0 holds the block idle.
REQ-006 pwm_in  input  1  asynchronous PWM signal to measure.
REQ-007 period  output  CNT_W  last measured rising-to-rising interval in clk cycles.
REQ-008 high_time  output  CNT_W  last measured rising-to-falling interval in clk cycles.
REQ-009 valid  output  1  one-cycle strobe; period and high_time were updated this cycle.
REQ-010 stuck  output  1  no edge seen for 2^CNT_W-1 cycles; the signal is at a constant level.
REQ-011 stuck_level  output  1  synchronized pwm_in level when stuck was set.

Function
REQ-012 pwm_in SHALL pass through SYNC_STAGES flops, then one edge-detect flop; rise = sync high and prev low; fall = sync low and prev high.
REQ-013 FSM states SHALL be IDLE, HIGH and LOW.
REQ-014 IDLE: on rise go to HIGH and set cnt=1; valid SHALL stay 0 because the first edge gives no measurement.
REQ-015 HIGH: cnt increments each cycle; on fall latch hf=cnt internally, go to LOW, and cnt keeps incrementing.
REQ-016 LOW: on rise load period<=cnt and high_time<=hf, pulse valid for exactly 1 cycle, set cnt=1, go to HIGH.
REQ-017 A PWM input with period P cycles and high phase H cycles SHALL yield period=P and high_time=H.
REQ-018 valid and the outputs SHALL update on the same clock edge at which rise is detected, SYNC_STAGES+1 edges after the first clk sample of pwm_in high.
REQ-019 Timeout: if cnt reaches 2^CNT_W-1 in HIGH or LOW with no qualifying edge, the block SHALL do all of the following on that edge:
  - set stuck=1;
  - set stuck_level to the current synchronized level;
  - go to IDLE;
  - keep period and high_time unchanged.
REQ-020 The counter SHALL never wrap; timeout takes priority over incrementing.
REQ-021 stuck SHALL clear on the next rise detected in IDLE.
REQ-022 stuck_level SHALL hold its value until the next timeout or reset.
REQ-023 ena=0 SHALL force IDLE and cnt=0 on the next edge and hold valid=0.
REQ-024 With ena=0, period, high_time, stuck and stuck_level SHALL hold their values.
REQ-025 When ena returns to 1, the first rise SHALL be treated per REQ-014.
REQ-026 Minimum measurable input: P=2, H=1 (pwm_in toggling every clk) SHALL give period=2 and high_time=1 on every valid.
REQ-027 valid SHALL never be asserted on two consecutive cycles.

Reset
REQ-028 rst=1 SHALL, on the next clk edge, set the following regardless of ena and FSM state:
  - FSM to IDLE;
  - cnt=0 and hf=0;
  - period=0 and high_time=0;
  - valid=0, stuck=0, stuck_level=0;
  - all synchronizer and edge flops to 0.
REQ-029 Reset mid-measurement SHALL discard the partial count; the first rise after release is treated per REQ-014.

Verification
REQ-030 PWM P=10, H=3, ena=1 -> first valid on the 2nd rise with period=10, high_time=3; then valid every 10 cycles, never back-to-back.
REQ-031 pwm_in toggling every clk -> period=2, high_time=1 on each valid.
REQ-032 CNT_W=8, pwm_in held high after one rise -> stuck=1 and stuck_level=1 exactly 254 cycles after the cnt=1 cycle; period and high_time unchanged.
REQ-033 Same as REQ-032 with pwm_in held low, then PWM P=20, H=5 resumes -> stuck clears on the first rise; the next valid gives 20/5.
REQ-034 rst pulsed mid high phase of a P=16, H=8 stream -> all outputs 0 the next cycle; the first valid after release gives 16/8 only after two rises.
REQ-035 ena dropped for 5 cycles mid-stream, then raised -> no valid while low, outputs held, measurement restarts per REQ-014.
